carryskip_adder_pipe: RTL
=========================

# carryskip_adder_pipe

- Parametrised, pipelined carry-skip adder/subtractor.
- Splits a WIDTH-bit operation into WIDTH/BLOCK skip blocks, with one register stage per block.
- Accepts one operation per cycle over a valid/ready handshake and returns sum, carry-out and signed overflow after a fixed latency.
- Arithmetic datapath for the 8-bit TinyTapeout wrappers and wider internal users; the wrapper keeps ui_in/uio_in as operand sources.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of BLOCK.
- BLOCK, 4, bits per skip block; NBLK = WIDTH/BLOCK ≥ 1.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept the beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0: A+B+cin, 1: A−B−cin
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB (no-borrow flag when sub=1)
- ovf  out  1  two's-complement overflow

## Operation
- Effective operands:
  - B' = sub ? ~b : b.
  - Effective carry-in c0 = cin ^ sub.
- Block k (bits k·BLOCK .. k·BLOCK+BLOCK−1) does the following:
  - Ripple adds A and B' slices with carry ck.
  - Propagate Pk = &(A_k ^ B'_k).
  - Carry-out ck+1 = Pk ? ck : ripple carry-out.
- Stage k evaluates block k and registers:
  - sum slice k, ck+1, valid bit;
  - all not-yet-consumed upper slices of A, B' (skew);
  - all already-computed lower sum slices (deskew).
- Final stage:
  - cout = cNBLK.
  - ovf = carry into MSB XOR cNBLK.
- Widths:
  - Results are exactly WIDTH bits; no truncation other than cout.
  - The last block may be any BLOCK (uniform); no partial blocks.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - A beat transfers when in_valid & in_ready.
  - On stall, every stage holds, including bubbles; no bubble compression.
  - When not stalled, every stage advances by one.
  - A beat with in_valid=0 inserts a bubble (valid bit 0).
- The consumer sees sum/cout/ovf stable while out_valid=1 and out_ready=0.
- Ordering: results leave in acceptance order; none dropped, none duplicated.
- Elaboration check: WIDTH % BLOCK ≠ 0 or BLOCK < 1 is a fatal elaboration error.

## Timing
- Reset:
  - All valid bits 0.
  - out_valid=0, sum=0, cout=0, ovf=0; in_ready=1.
  - Outputs take these values immediately on rst assertion, not at the next edge.
- Reset mid-operation: all in-flight beats discarded; none emerge after release.
- First acceptance is possible in the first rising edge with rst low.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NBLK−1 (NBLK register stages, NBLK=1 → next cycle).
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.
- in_ready falls in the same cycle out_ready drops with out_valid=1.
- Critical path per stage: one BLOCK-bit ripple plus one skip mux.

## Structure
- Package carryskip_pkg:
  - function nblk(width, block);
  - typedef for stage record (valid, carry, sum slices, remaining operands) built by WIDTH.
- Sub-module carryskip_block (combinational, BLOCK-parametrised):
  - inputs a, b, ci; outputs s, co, p, c_msb_in.
  - Instantiated NBLK times via generate.
- Top handles skew/deskew registers, stall control and output mapping.

## Test plan
- WIDTH=16, BLOCK=4, a=0x00FF, b=0x0001, sub=0, cin=0 → 4 cycles later sum=0x0100, cout=0, ovf=0.
- a=0x5555, b=0xAAAA, cin=1 (all blocks propagate, pure skip path) → sum=0x0000, cout=1, ovf=0.
- a=0x8000, b=0x0001, sub=1, cin=0 → sum=0x7FFF, cout=1, ovf=1.
- a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1.
- Back-to-back beats:
  - Stimulus: 8 beats (a=i, b=0x1000·i), out_ready low on cycles 5–7.
  - Required: in_ready low exactly while stalled, outputs held stable, 8 results in order, no loss or duplicate.
- Reset pulse with 3 beats in flight:
  - out_valid=0 immediately.
  - No result emerges within 2·NBLK cycles after release.
  - The next accepted beat arrives with the normal latency.

Source files
------------

// File: rtl/carryskip_adder_pipe_pkg.sv
// carryskip_pkg: shared sizing helpers for the pipelined carry-skip adder.
// Exports nblk() (number of skip blocks) and default width/block constants.
package carryskip_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  function automatic int nblk(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

endpackage

// File: rtl/carryskip_adder_pipe_if.sv
// carryskip_adder_pipe_if: operand/result valid-ready bundle.
// master = producer/consumer side, slave = adder side.
interface carryskip_adder_pipe_if
  import carryskip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/carryskip_adder_pipe_block.sv
// carryskip_block: combinational BLOCK-bit ripple slice with skip mux.
// Ports: a, b, ci in; s, co (skipped carry), p (propagate), c_msb_in out.
module carryskip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             p,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = ci;
    c_msb_in = ci;
    s        = '0;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    p  = &(a ^ b);
    // full propagate: carry-in bypasses the ripple chain
    co = p ? ci : c;
  end

endmodule

// File: rtl/carryskip_adder_pipe.sv
// carryskip_adder_pipe: NBLK-stage pipelined carry-skip add/sub.
// Ports: clk, rst (async high), bus (slave: operands in, sum/cout/ovf out).
module carryskip_adder_pipe
  import carryskip_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input logic                  clk,
  input logic                  rst,
  carryskip_adder_pipe_if.slave bus
);

  localparam int NBLK = nblk(WIDTH, BLOCK);

  if (BLOCK < 1) begin : g_bad_block
    $fatal(1, "carryskip_adder_pipe: BLOCK must be >= 1");
  end else if (WIDTH % BLOCK != 0) begin : g_bad_width
    $fatal(1, "carryskip_adder_pipe: WIDTH not a multiple of BLOCK");
  end

  // a/b carry the not-yet-consumed operand slices (skew),
  // sum accumulates the already-computed slices (deskew)
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t st_q [NBLK];
  stage_t st_d [NBLK];

  logic out_valid;
  logic stall;

  assign out_valid    = st_q[NBLK-1].valid;
  assign stall        = out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    localparam bit IS_LAST = (k == NBLK - 1);

    stage_t           src;
    logic [BLOCK-1:0] s;
    logic             co;
    logic             p;
    logic             c_msb;
    logic [WIDTH-1:0] merged;
    logic             unused_p;

    if (k == 0) begin : g_src_in
      assign src.valid = bus.in_valid;
      assign src.carry = bus.cin ^ bus.sub;
      assign src.ovf   = 1'b0;
      assign src.sum   = '0;
      assign src.a     = bus.a;
      assign src.b     = bus.sub ? ~bus.b : bus.b;
    end else begin : g_src_reg
      assign src = st_q[k-1];
    end

    carryskip_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a       (src.a[k*BLOCK +: BLOCK]),
      .b       (src.b[k*BLOCK +: BLOCK]),
      .ci      (src.carry),
      .s       (s),
      .co      (co),
      .p       (p),
      .c_msb_in(c_msb)
    );

    assign unused_p = p;

    always_comb begin
      merged = src.sum;
      merged[k*BLOCK +: BLOCK] = s;
    end

    assign st_d[k].valid = src.valid;
    assign st_d[k].carry = co;
    assign st_d[k].ovf   = IS_LAST ? (c_msb ^ co) : src.ovf;
    assign st_d[k].sum   = merged;
    assign st_d[k].a     = src.a;
    assign st_d[k].b     = src.b;
  end

  // stall freezes every stage, bubbles included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) st_q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < NBLK; k++) st_q[k] <= st_d[k];
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.sum       = st_q[NBLK-1].sum;
  assign bus.cout      = st_q[NBLK-1].carry;
  assign bus.ovf       = st_q[NBLK-1].ovf;

endmodule
